// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1:4 valid/ready stream demultiplexer.
package stream_demux_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int N_OUT         = 4;

    typedef logic [1:0] chan_idx_t;

endpackage

// File: rtl/stream_demux_1_2.sv
// One-entry registered valid/ready 1:2 demux; the stored word is offered on the
// output selected by its captured sel bit, optionally carrying sideband bits.
module stream_demux_1_2 #(
    parameter  int WIDTH  = 4,
    parameter  int SIDE_W = 0,
    localparam int SW     = (SIDE_W > 0) ? SIDE_W : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic [SW-1:0]    in_side,
    output logic [1:0]       out_valid,
    input  logic [1:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_side
);

    logic             valid_q, valid_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             out_fire;
    logic             load;

    // NOTE: every always_comb output gets a default-free full assignment on all
    // paths, so no latch can be inferred.
    always_comb begin
        out_fire = valid_q && out_ready[sel_q];
        // Register may refill on the same edge its word leaves (pass-through).
        in_ready = !valid_q || out_fire;
        load     = in_valid && in_ready;
        valid_d  = load || (valid_q && !out_fire);
        sel_d    = load ? in_sel  : sel_q;
        data_d   = load ? in_data : data_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = {valid_q & sel_q, valid_q & ~sel_q};
    assign out_data  = data_q;

    if (SIDE_W > 0) begin : g_side
        logic [SW-1:0] side_q, side_d;

        always_comb begin
            side_d = load ? in_side : side_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                side_q <= '0;
            end else begin
                side_q <= side_d;
            end
        end

        assign out_side = side_q;
    end else begin : g_no_side
        logic side_unused;
        assign side_unused = |in_side;
        assign out_side    = '0;
    end

endmodule

// File: rtl/stream_demux_1_4.sv
// 1:4 valid/ready stream demux built as a two-level tree of registered 1:2
// stages: the top routes on in_sel[1] and carries in_sel[0] to the leaves.
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  chan_idx_t              in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data
);

    logic [1:0]       top_valid;
    logic [1:0]       leaf_ready;
    logic [WIDTH-1:0] top_data;
    logic [0:0]       top_side;
    logic [WIDTH-1:0] leaf_data [2];
    logic [1:0]       leaf_side_unused;

    stream_demux_1_2 #(
        .WIDTH  (WIDTH),
        .SIDE_W (1)
    ) u_top (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel[1]),
        .in_side   (in_sel[0]),
        .out_valid (top_valid),
        .out_ready (leaf_ready),
        .out_data  (top_data),
        .out_side  (top_side)
    );

    for (genvar j = 0; j < 2; j++) begin : g_leaf
        // Leaf j serves channels 2j and 2j+1; both see the same stored word.
        stream_demux_1_2 #(
            .WIDTH  (WIDTH),
            .SIDE_W (0)
        ) u_leaf (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (top_valid[j]),
            .in_ready  (leaf_ready[j]),
            .in_data   (top_data),
            .in_sel    (top_side[0]),
            .in_side   (1'b0),
            .out_valid (out_valid[2*j +: 2]),
            .out_ready (out_ready[2*j +: 2]),
            .out_data  (leaf_data[j]),
            .out_side  (leaf_side_unused[j +: 1])
        );

        assign out_data[(2*j)*WIDTH   +: WIDTH] = leaf_data[j];
        assign out_data[(2*j+1)*WIDTH +: WIDTH] = leaf_data[j];
    end

endmodule

// File: doc/stream_demux_1_4.md
STREAM_DEMUX_1_4 -- requirements
Module: stream_demux_1_4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data word width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream word is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the upstream word.
REQ-007 The block SHALL have port in_sel, input, 2 bits: destination channel index 0..3.
REQ-008 The block SHALL have port out_valid, output, 4 bits: per-channel word present, bit k for channel k.
REQ-009 The block SHALL have port out_ready, input, 4 bits: per-channel downstream accept.
REQ-010 The block SHALL have port out_data, output, 4 x WIDTH bits, packed: the word for channel k.

Function
REQ-011 A transfer SHALL occur on a rising edge where valid and ready are both 1, on input and on each output independently.
REQ-012 in_data and in_sel SHALL be ignored while in_valid is 0.
REQ-013 The block SHALL route each accepted word to channel in_sel only and SHALL never duplicate or drop it.
REQ-014 The datapath SHALL be two register stages: a top 1:2 stage routing on in_sel[1] and carrying in_sel[0] as sideband; two leaf 1:2 stages routing on sel[0], whose registers drive out_valid and out_data directly.
REQ-015 For a word accepted at edge t with no back-pressure, out_valid[in_sel] SHALL be 1 from immediately after edge t+1, so latency is 2 edges.
REQ-016 Each stage register SHALL load when it is empty, or when it is full and its current word leaves on the same edge (pass-through).
REQ-017 in_ready SHALL be combinational: 1 when the top register is empty, or when its target leaf can load on this edge.
REQ-018 With all out_ready at 1, the block SHALL sustain one transfer per cycle with in_ready held at 1.
REQ-019 While out_valid[k] is 1 and out_ready[k] is 0, out_valid[k] and out_data[k] SHALL hold stable.
REQ-020 out_ready[k] SHALL have no effect while out_valid[k] is 0.
REQ-021 Words to the same channel SHALL emerge in acceptance order.
REQ-022 A stalled channel SHALL block only words queued behind it in the same stage register; a word for the other leaf pair SHALL still advance when the top register holds a word for that pair.
REQ-023 When a leaf is full and stalled and the top register holds a word for that leaf, in_ready SHALL be 0; this is head-of-line blocking by design.
REQ-024 Simultaneous input accept and output release on one edge SHALL be handled losslessly, with the stage occupancy unchanged.
REQ-025 Total capacity SHALL be 3 words: one in the top register and one in each leaf.

Reset
REQ-026 While rst_n is 0, all stage valid bits SHALL be 0 immediately, independent of clk, so out_valid is 4'b0000.
REQ-027 Reset SHALL clear out_data and all stored sideband to 0.
REQ-028 in_ready SHALL read 1 during reset and after release, because all registers are empty.
REQ-029 Assertion of rst_n low mid-operation SHALL discard all in-flight words, with no partial output afterwards.
REQ-030 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 Package stream_demux_pkg SHALL hold the default WIDTH constant, N_OUT = 4, and the channel-index typedef (2-bit).
REQ-032 The sub-module stream_demux_1_2 SHALL be a one-entry registered valid/ready 1:2 stream demux with parameters WIDTH and SIDE_W (sideband width; 0 is allowed).
REQ-033 The top instance SHALL be instantiated with SIDE_W = 1 and the two leaves with SIDE_W = 0, giving 3 instances in total with no other state.

Verification
REQ-034 Reset then idle: rst_n low mid-stream, with words in flight -> out_valid is 0000 immediately and in_ready is 1; no stale word appears after release.
REQ-035 Single word: in_data=4'hA, in_sel=2 accepted at edge t, all out_ready=1 -> out_valid=0100 and out_data[2]=A after edge t+1, with one-cycle pulse only.
REQ-036 Streaming: 8 back-to-back words with sel 0,1,2,3,0,1,2,3 and all ready -> in_ready is constantly 1 and each channel receives its 2 words in order at 1 word/cycle.
REQ-037 Back-pressure: out_ready[1]=0 and 3 words sent to channel 1 -> 2 words are stored, then in_ready=0 and out_data[1] is held stable; releasing out_ready[1] delivers the 3 words in order.
REQ-038 Independent path: channel 0 stalled with its leaf full, then a word to channel 3 -> it is delivered 2 edges later while channel 0 is still stalled.
REQ-039 Random scoreboard: 10k random valid/ready/sel values -> no loss, duplication or reorder per channel, and valid/data stability is held under stall.
